// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, framebuffer geometry and the fixed
// colour-index palette used by the scanout path.
package vga_timing_pkg;

    localparam logic [9:0] H_VISIBLE    = 10'd640;
    localparam logic [9:0] H_FP         = 10'd16;
    localparam logic [9:0] H_SYNC       = 10'd96;
    localparam logic [9:0] H_BP         = 10'd48;
    localparam logic [9:0] H_TOTAL      = 10'd800;
    localparam logic [9:0] H_SYNC_START = H_VISIBLE + H_FP;
    localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam logic [9:0] H_LAST       = H_TOTAL - 10'd1;

    localparam logic [9:0] V_VISIBLE    = 10'd480;
    localparam logic [9:0] V_FP         = 10'd10;
    localparam logic [9:0] V_SYNC       = 10'd2;
    localparam logic [9:0] V_BP         = 10'd33;
    localparam logic [9:0] V_TOTAL      = 10'd525;
    localparam logic [9:0] V_SYNC_START = V_VISIBLE + V_FP;
    localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC;
    localparam logic [9:0] V_LAST       = V_TOTAL - 10'd1;

    localparam logic [18:0] FB_WIDTH  = 19'd640;
    localparam logic [18:0] FB_PIXELS = 19'd307200;
    localparam logic [18:0] FB_LAST   = FB_PIXELS - 19'd1;

    typedef logic [2:0]  color_idx_t;
    typedef logic [23:0] rgb_t;

    // Entry 0 is the leftmost element of the concatenation.
    localparam logic [0:7][23:0] PALETTE = {
        24'h000000, 24'hFFFFFF, 24'hFF0000, 24'h00FF00,
        24'h0000FF, 24'hFFFF00, 24'h00FFFF, 24'hFF00FF
    };

    typedef struct packed {
        logic hs_n;
        logic vs_n;
        logic visible;
        logic frame;
    } pix_ctl_t;

    localparam pix_ctl_t PIX_CTL_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, visible: 1'b0, frame: 1'b0};

    function automatic rgb_t palette_lookup(input color_idx_t idx);
        return PALETTE[idx];
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Free-running 800x525 pixel/line counters with raw (undelayed) sync,
// visible and start-of-frame decodes.
module vga_timing_gen
    import vga_timing_pkg::*;
(
    input  logic clock,
    input  logic reset,
    output logic hs_raw,
    output logic vs_raw,
    output logic visible,
    output logic frame_flag
);

    logic [9:0] h_q, h_d;
    logic [9:0] v_q, v_d;

    always_comb begin
        h_d = h_q + 10'd1;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign hs_raw     = !((h_q >= H_SYNC_START) && (h_q < H_SYNC_END));
    assign vs_raw     = !((v_q >= V_SYNC_START) && (v_q < V_SYNC_END));
    assign visible    = (h_q < H_VISIBLE) && (v_q < V_VISIBLE);
    assign frame_flag = (h_q == '0) && (v_q == '0);

endmodule

// File: rtl/index_mem_scanout.sv
// Scans the colour-index framebuffer out to the VGA DAC: one read per visible
// pixel, palette mapping, and sync/blank delayed to line up with the colour.
module index_mem_scanout
    import vga_timing_pkg::*;
#(
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic [18:0] mem_raddr,
    output logic        mem_renable,
    input  logic [2:0]  mem_rdata,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic        frame_start
);

    localparam int unsigned DEPTH = RD_LATENCY + 1;

    logic     hs_raw, vs_raw, visible, frame_flag;
    pix_ctl_t cur_ctl;

    vga_timing_gen u_timing (
        .clock      (clock),
        .reset      (reset),
        .hs_raw     (hs_raw),
        .vs_raw     (vs_raw),
        .visible    (visible),
        .frame_flag (frame_flag)
    );

    assign cur_ctl = '{hs_n: hs_raw, vs_n: vs_raw, visible: visible, frame: frame_flag};

    // Linear address advances per visible pixel instead of computing y*640+x.
    logic [18:0] addr_q, addr_d;

    always_comb begin
        addr_d = addr_q;
        if (visible) begin
            addr_d = (addr_q == FB_LAST) ? '0 : addr_q + 19'd1;
        end
    end

    pix_ctl_t [DEPTH-1:0] dly_q, dly_d;
    rgb_t                 rgb_q, rgb_d;

    always_comb begin
        dly_d = {dly_q[DEPTH-2:0], cur_ctl};
    end

    // Stage RD_LATENCY-1 carries the visible flag of the pixel whose data is on mem_rdata now.
    always_comb begin
        rgb_d = '0;
        if (dly_q[RD_LATENCY-1].visible) begin
            rgb_d = palette_lookup(color_idx_t'(mem_rdata));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q <= '0;
            dly_q  <= {DEPTH{PIX_CTL_IDLE}};
            rgb_q  <= '0;
        end else begin
            addr_q <= addr_d;
            dly_q  <= dly_d;
            rgb_q  <= rgb_d;
        end
    end

    assign mem_raddr   = addr_q;
    assign mem_renable = visible;

    assign vga_r       = rgb_q[23:16];
    assign vga_g       = rgb_q[15:8];
    assign vga_b       = rgb_q[7:0];
    assign vga_hs      = dly_q[DEPTH-1].hs_n;
    assign vga_vs      = dly_q[DEPTH-1].vs_n;
    assign vga_blank_n = dly_q[DEPTH-1].visible;
    assign frame_start = dly_q[DEPTH-1].frame;

endmodule

// File: tb/tb_index_mem_scanout.sv
// Bench for index_mem_scanout: latency-2 memory model, scoreboard of pin
// values predicted from an independent counter model, plus directed checks.
module tb_index_mem_scanout;

    localparam int unsigned RDL = 2;
    localparam int unsigned L   = RDL + 1;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        blank_n;
        logic        fs;
        logic [23:0] rgb;
    } pins_t;

    typedef struct {
        logic [2:0]  idx;
        logic [23:0] rgb;
    } pal_vec_t;

    localparam pins_t PINS_IDLE = '{hs: 1'b1, vs: 1'b1, blank_n: 1'b0, fs: 1'b0, rgb: 24'h0};

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [18:0] mem_raddr;
    logic        mem_renable;
    logic [2:0]  mem_rdata = 3'd0;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs, vga_blank_n, frame_start;

    index_mem_scanout #(.RD_LATENCY(RDL)) dut (
        .clock       (clock),
        .reset       (reset),
        .mem_raddr   (mem_raddr),
        .mem_renable (mem_renable),
        .mem_rdata   (mem_rdata),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vga_blank_n (vga_blank_n),
        .frame_start (frame_start)
    );

    always #5 clock = ~clock;

    int         n_assert = 0;
    int         n_fail   = 0;
    pal_vec_t   pal_tbl [8];
    pins_t      sb [$];
    int         mh = 0, mv = 0, cyc = 0;
    logic       rst_edge = 1'b1;
    int         mode = 0;
    logic [2:0] const_idx = 3'd0;
    logic [2:0] pipe [RDL+1];

    logic       prev_hs = 1'b1, prev_blank = 1'b0, seen_fs = 1'b0;
    int         last_fall = -1, pix = 0, n_yellow = 0, yellow_pix = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d h=%0d v=%0d: got %0h expected %0h", name, cyc, mh, mv, act, exp);
        end
    endtask

    function automatic logic [2:0] mem_fn(input int addr);
        case (mode)
            0:       return (addr == 3) ? 3'd5 : 3'd0;
            1:       return const_idx;
            default: return addr[2:0] ^ addr[5:3];
        endcase
    endfunction

    function automatic logic [23:0] ref_rgb(input logic [2:0] idx);
        for (int i = 0; i < 8; i++) begin
            if (pal_tbl[i].idx == idx) return pal_tbl[i].rgb;
        end
        return 24'h0;
    endfunction

    function automatic pins_t exp_pins(input int h, input int v);
        pins_t p;
        p.hs      = !(h >= 656 && h < 752);
        p.vs      = !(v >= 490 && v < 492);
        p.blank_n = (h < 640) && (v < 480);
        p.fs      = (h == 0) && (v == 0);
        p.rgb     = p.blank_n ? ref_rgb(mem_fn(v * 640 + h)) : 24'h0;
        return p;
    endfunction

    // One clock: memory model, pin/address checks, monitors, then set reset for the next edge.
    task automatic step(input logic r);
        pins_t act, exp;
        int    ea;
        logic  vis;
        @(negedge clock);
        if (rst_edge) begin
            cyc = 0;
            prev_hs = 1'b1; prev_blank = 1'b0; seen_fs = 1'b0; last_fall = -1; pix = 0;
        end else begin
            cyc++;
        end

        for (int k = RDL; k > 0; k--) pipe[k] = pipe[k-1];
        pipe[0]   = mem_fn(int'(mem_raddr));
        mem_rdata = pipe[RDL];

        act = {vga_hs, vga_vs, vga_blank_n, frame_start, vga_r, vga_g, vga_b};
        exp = sb.pop_front();
        chk("pins", 32'(act), 32'(exp));

        vis = (mh < 640) && (mv < 480);
        ea  = vis ? mv * 640 + mh : ((mv < 479) ? (mv + 1) * 640 : 0);
        chk("raddr", 32'(mem_raddr), ea);
        chk("renable", 32'(mem_renable), 32'(vis));
        if (mh == 639 && mv == 0) chk("raddr_639_0", 32'(mem_raddr), 639);
        if (mh == 0 && mv == 1)   chk("raddr_0_1", 32'(mem_raddr), 640);

        if (!rst_edge) begin
            if (prev_hs && !vga_hs) begin
                if (last_fall < 0) chk("hs_first_fall", cyc, 656 + L);
                else               chk("line_period", cyc - last_fall, 800);
                last_fall = cyc;
            end
            if (!prev_hs && vga_hs && last_fall >= 0) chk("hs_width", cyc - last_fall, 96);
            if (vga_blank_n) pix = prev_blank ? pix + 1 : 0;
            if (prev_blank && !vga_blank_n) chk("blank_run", pix + 1, 640);
            if (frame_start && !seen_fs) begin
                chk("frame_start_cycle", cyc, L);
                seen_fs = 1'b1;
            end
            if (vga_blank_n && {vga_r, vga_g, vga_b} == 24'hFFFF00) begin
                n_yellow++;
                yellow_pix = pix;
            end
        end
        prev_hs    = vga_hs;
        prev_blank = vga_blank_n;

        sb.push_back(exp_pins(mh, mv));
        reset    = r;
        rst_edge = r;
        if (r) begin
            mh = 0; mv = 0;
            sb.delete();
            repeat (L) sb.push_back(PINS_IDLE);
        end else begin
            mh++;
            if (mh == 800) begin
                mh = 0; mv++;
                if (mv == 525) mv = 0;
            end
        end
    endtask

    task automatic run_to(input int h, input int v);
        int n = 0;
        while (!(mh == h && mv == v) && n < 60000) begin
            step(1'b0);
            n++;
        end
        chk("run_to_reached", 32'(mh == h && mv == v), 32'd1);
    endtask

    initial begin
        pal_tbl = '{'{3'd0, 24'h000000}, '{3'd1, 24'hFFFFFF}, '{3'd2, 24'hFF0000}, '{3'd3, 24'h00FF00},
                    '{3'd4, 24'h0000FF}, '{3'd5, 24'hFFFF00}, '{3'd6, 24'h00FFFF}, '{3'd7, 24'hFF00FF}};
        for (int k = 0; k <= RDL; k++) pipe[k] = 3'd0;
        repeat (L) sb.push_back(PINS_IDLE);

        repeat (4) step(1'b1);
        step(1'b0);
        chk("first_raddr", 32'(mem_raddr), 0);
        chk("first_renable", 32'(mem_renable), 1);

        run_to(0, 2);
        chk("yellow_count", n_yellow, 1);
        chk("yellow_pixel", yellow_pix, 3);

        mode = 1; const_idx = 3'd7;
        run_to(0, 4);

        for (int i = 0; i < 8; i++) begin
            run_to(0, 4 + i);
            const_idx = pal_tbl[i].idx;
            repeat (L + 20) step(1'b0);
            chk("palette_tbl", 32'({vga_r, vga_g, vga_b}), 32'(pal_tbl[i].rgb));
        end

        mode = 2;
        run_to(0, 15);

        mode = 1; const_idx = 3'd3;
        run_to(300, 40);
        step(1'b1);
        step(1'b1);
        chk("reset_inactive", 32'({vga_hs, vga_vs, vga_blank_n, frame_start, vga_r, vga_g, vga_b}),
            32'(PINS_IDLE));
        step(1'b1);
        step(1'b0);
        chk("restart_raddr", 32'(mem_raddr), 0);
        chk("restart_renable", 32'(mem_renable), 1);

        mode = 2;
        run_to(0, 2);
        chk("restart_frame_seen", 32'(seen_fs), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

endmodule
